seq_pair_tx: RTL

Transmit-side counterpart to the two-line sequential detector (`seq_circuit`). It accepts a parallel word over a valid/ready handshake and serialises it as 2-bit symbols on lines `a`/`b`, MSB pair first. Each symbol is held for a programmable number of clock cycles, which reproduces the stimulus style the detector consumes. The block sits upstream of the detector; a frame-end strobe `t` marks the last symbol.

---
 rtl/seq_pair_pkg.sv | 23 ++
 rtl/seq_pair_tx_symbol_timer.sv | 44 ++++
 rtl/seq_pair_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_pair_pkg.sv
// ---------------------------------------------------------------------------
// seq_pair_pkg : shared types and parameter checks for the pair transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_pair_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  localparam int GAP_CYCLES = 1;

  function automatic bit params_ok(input int word_w, input int hold);
    return (word_w >= 2) && ((word_w % 2) == 0) && (hold >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_pair_tx_symbol_timer.sv
// ---------------------------------------------------------------------------
// symbol_timer : loadable down-counter with zero flag (per-symbol hold time)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module symbol_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/seq_pair_tx.sv
// ---------------------------------------------------------------------------
// seq_pair_tx : serialises a word as 2-bit symbols on a/b, MSB pair first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_pair_tx
  import seq_pair_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int HOLD   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              a,
  output logic              b,
  output logic              t,
  output logic              busy
);

  localparam int SYMS   = WORD_W / 2;
  localparam int SYM_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SYMS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  generate
    if (!params_ok(WORD_W, HOLD)) begin : g_bad_params
      $error("seq_pair_tx: WORD_W must be even and >= 2, HOLD must be >= 1");
    end
    if (GAP_CYCLES != 1) begin : g_bad_gap
      $error("seq_pair_tx: GAP state is a single cycle");
    end
  endgenerate

  tx_state_t         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [SYM_W-1:0]  sym_q,   sym_d;
  logic              hold_load;
  logic              hold_dec;
  logic              hold_zero;
  logic [HOLD_W-1:0] hold_value;

  symbol_timer #(
    .W (HOLD_W)
  ) u_hold_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (hold_load),
    .load_val_i (HOLD_LAST),
    .dec_i      (hold_dec),
    .value_o    (hold_value),
    .zero_o     (hold_zero)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    sym_d     = sym_q;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = data_in;
          sym_d     = SYM_LAST;
          hold_load = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (hold_zero) begin
          if (sym_q != '0) begin
            shreg_d   = shreg_q << 2;
            sym_d     = sym_q - 1'b1;
            hold_load = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          hold_dec = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sym_q   <= sym_d;
    end
  end

  // Outputs decode registered state only; load/data_in never reach them.
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign a     = (state_q == SEND) & shreg_q[WORD_W-1];
  assign b     = (state_q == SEND) & shreg_q[WORD_W-2];
  assign t     = (state_q == SEND) & (sym_q == '0);

endmodule

`default_nettype wire
